// File: rtl/lsu_bus_if.sv
// lsu_bus_if: load/store unit between the core datapath and the external data bus.
// Accepts one load/store request, runs a registered bus cycle (MREQ held until
// ACKD_n), returns lane-selected, sign/zero-extended load data and stalls the
// core until the access completes. Misaligned or invalid accesses are answered
// with rsp_err and no bus cycle.
// Optional feature: define LSU_ACK_TIMEOUT_EN to abort a bus cycle with rsp_err
// after ACK_TIMEOUT cycles without an acknowledge.
module lsu_bus_if #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] DAD,
    output logic [31:0] ddt_o,
    output logic        ddt_oe,
    input  logic [31:0] ddt_i,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    input  logic        ACKD_n
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_dad;
    logic [31:0] r_ddt_o;
    logic        r_ddt_oe;
    logic        r_mreq;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [1:0]  r_lane;
    logic [2:0]  r_funct3;
    logic        w_req_ok;

`ifdef LSU_ACK_TIMEOUT_EN
    localparam int TW = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;
    logic [TW-1:0] r_tcnt;
`else
    // The timeout limit has no effect when the watchdog is not built.
    logic w_unused_cfg;
    assign w_unused_cfg = (ACK_TIMEOUT == 0);
`endif

    // Legal funct3 for the direction, and natural alignment for the access size.
    function automatic logic f_req_ok(input logic wr, input logic [2:0] f3, input logic [1:0] lane);
        logic legal;
        logic aligned;
        if (wr)
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
        case (f3[1:0])
            2'b01:   aligned = ~lane[0];
            2'b10:   aligned = (lane == 2'b00);
            default: aligned = 1'b1;
        endcase
        return legal & aligned;
    endfunction

    // Bus SIZE encoding: 00 word, 01 half, 10 byte.
    function automatic logic [1:0] f_size_code(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return 2'b10;
            2'b01:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Place store data on its little-endian byte lanes; unused lanes are zero.
    function automatic logic [31:0] f_store_lanes(input logic [1:0] f3_lo, input logic [1:0] lane,
                                                  input logic [31:0] wd);
        case (f3_lo)
            2'b00:   return {24'd0, wd[7:0]} << {lane, 3'b000};
            2'b01:   return {16'd0, wd[15:0]} << {lane[1], 4'b0000};
            default: return wd;
        endcase
    endfunction

    // Select the addressed lane from the bus word and sign/zero-extend it.
    function automatic logic [31:0] f_load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                                  input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    assign w_req_ok = f_req_ok(req_write, req_funct3, req_addr[1:0]);

    // Stall the core while a request is being taken or the bus cycle is open.
    assign stall = ~rst & (((r_state == S_IDLE) & req_valid) | (r_state == S_BUS));

    // Request/bus/response FSM with all bus and response outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dad       <= '0;
            r_ddt_o     <= '0;
            r_ddt_oe    <= 1'b0;
            r_mreq      <= 1'b0;
            r_write     <= 1'b0;
            r_size      <= 2'b00;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_lane      <= 2'b00;
            r_funct3    <= 3'b000;
`ifdef LSU_ACK_TIMEOUT_EN
            r_tcnt      <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (w_req_ok) begin
                            r_dad    <= {req_addr[31:2], 2'b00};
                            r_size   <= f_size_code(req_funct3[1:0]);
                            r_write  <= req_write;
                            r_ddt_o  <= f_store_lanes(req_funct3[1:0], req_addr[1:0], req_wdata);
                            r_ddt_oe <= req_write;
                            r_mreq   <= 1'b1;
                            r_lane   <= req_addr[1:0];
                            r_funct3 <= req_funct3;
`ifdef LSU_ACK_TIMEOUT_EN
                            r_tcnt   <= '0;
`endif
                            r_state  <= S_BUS;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_BUS: begin
                    if (!ACKD_n) begin
                        r_rsp_rdata <= r_write ? 32'd0 : f_load_extend(r_funct3, r_lane, ddt_i);
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_mreq      <= 1'b0;
                        r_write     <= 1'b0;
                        r_ddt_oe    <= 1'b0;
                        r_state     <= S_RESP;
                    end
`ifdef LSU_ACK_TIMEOUT_EN
                    else if (r_tcnt == TW'(ACK_TIMEOUT - 1)) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_mreq      <= 1'b0;
                        r_write     <= 1'b0;
                        r_ddt_oe    <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign DAD       = r_dad;
    assign ddt_o     = r_ddt_o;
    assign ddt_oe    = r_ddt_oe;
    assign MREQ      = r_mreq;
    assign WRITE     = r_write;
    assign SIZE      = r_size;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Bench for lsu_bus_if: randomized and directed load/store requests, a memory
// responder with variable acknowledge delay, and scoreboard monitors for the
// bus cycle and the response.
module tb_lsu_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] DAD;
    logic [31:0] ddt_o;
    logic        ddt_oe;
    logic [31:0] ddt_i;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    logic        ACKD_n;

    always #5 clk = ~clk;

    lsu_bus_if dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .DAD(DAD), .ddt_o(ddt_o), .ddt_oe(ddt_oe), .ddt_i(ddt_i),
        .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .ACKD_n(ACKD_n)
    );

    typedef struct {
        logic [31:0] dad;
        logic [31:0] ddt;
        logic [1:0]  size;
        logic        wr;
        int          wt;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];

    int total = 0;
    int bad = 0;
    int wait_cur = 0;
    bit abort = 1'b0;

    // Monitor state
    bit          bm_prev = 1'b0;
    int          bm_len = 0;
    bus_t        bm_cur;
    logic [31:0] bm_act_dad = '0;
    logic [31:0] bm_act_ddt = '0;
    logic [31:0] exp_last_rdata = '0;
    logic        exp_last_err = 1'b0;
    logic [31:0] act_last_rdata = '0;
    logic        act_last_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic bit model_ok(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        if (wr) legal = (f3 <= 2);
        else    legal = (f3 <= 2) || (f3 == 4) || (f3 == 5);
        return legal && ((a % nbytes(f3)) == 0);
    endfunction

    function automatic logic [31:0] model_mask(input int nb);
        if (nb == 1) return 32'h0000_00FF;
        if (nb == 2) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] word);
        int nb;
        logic [31:0] v;
        logic [31:0] m;
        nb = nbytes(f3);
        m  = model_mask(nb);
        v  = (word >> (8 * (a % 4))) & m;
        if (f3 < 4 && nb < 4 && v >= ((m >> 1) + 1)) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] wd);
        return (wd & model_mask(nbytes(f3))) << (8 * (a % 4));
    endfunction

    function automatic logic [1:0] model_size(input logic [2:0] f3);
        case (nbytes(f3))
            1:       return 2'b10;
            2:       return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        int rcnt;
        rcnt = 0;
        ACKD_n = 1'b1;
        forever begin
            @(negedge clk);
            if (MREQ) begin
                ACKD_n = (rcnt == wait_cur) ? 1'b0 : 1'b1;
                rcnt++;
            end else begin
                ACKD_n = 1'($urandom_range(0, 1));
                rcnt = 0;
            end
        end
    end

    // ---------------- bus monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                bm_prev = 1'b0;
            end else if (MREQ) begin
                if (!bm_prev) begin
                    bm_len = 1;
                    bm_act_dad = DAD;
                    bm_act_ddt = ddt_o;
                    if (bus_q.size() == 0) begin
                        chk("bus_unexpected", 32'd1, 32'd0);
                    end else begin
                        bm_cur = bus_q.pop_front();
                        chk("bus_dad", DAD, bm_cur.dad);
                        chk("bus_size", 32'(SIZE), 32'(bm_cur.size));
                        chk("bus_write", 32'(WRITE), 32'(bm_cur.wr));
                        chk("bus_oe", 32'(ddt_oe), 32'(bm_cur.wr));
                        if (bm_cur.wr) chk("bus_ddt", ddt_o, bm_cur.ddt);
                    end
                end else begin
                    bm_len++;
                    chk("bus_stable_dad", DAD, bm_act_dad);
                    chk("bus_stable_ddt", ddt_o, bm_act_ddt);
                    chk("bus_stable_ctl", {30'd0, WRITE, ddt_oe}, {30'd0, bm_cur.wr, bm_cur.wr});
                end
                chk("bus_stall", 32'(stall), 32'd1);
            end else begin
                if (bm_prev && !abort) chk("bus_len", bm_len, bm_cur.wt + 1);
                chk("idle_oe_write", {30'd0, WRITE, ddt_oe}, 32'd0);
            end
            bm_prev = MREQ && !rst;
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_last_rdata = '0;
                exp_last_err = 1'b0;
            end else if (rsp_valid) begin
                act_last_rdata = rsp_rdata;
                act_last_err = rsp_err;
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    exp_last_rdata = e.rdata;
                    exp_last_err = e.err;
                end
                chk("rsp_mreq_low", 32'(MREQ), 32'd0);
            end else begin
                chk("rsp_hold", {rsp_rdata[30:0], rsp_err}, {exp_last_rdata[30:0], exp_last_err});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_txn(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] word, input int wt);
        bus_t b;
        rsp_t r;
        int n;
        int exp_lat;
        bit done;
        if (model_ok(wr, f3, addr)) begin
            b.dad  = addr & 32'hFFFF_FFFC;
            b.ddt  = model_store(f3, addr, wd);
            b.size = model_size(f3);
            b.wr   = wr;
            b.wt   = wt;
            bus_q.push_back(b);
            r.rdata = wr ? 32'd0 : model_load(f3, addr, word);
            r.err   = 1'b0;
            exp_lat = wt + 3;
        end else begin
            r.rdata = 32'd0;
            r.err   = 1'b1;
            exp_lat = 2;
        end
        rsp_q.push_back(r);
        wait_cur   = wt;
        ddt_i      = word;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                chk("stall_hold", 32'(stall), 32'd1);
                if (n >= 60) begin
                    chk("rsp_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end else if (n == 1) begin
                    @(posedge clk);
                    #1;
                    req_addr   = $urandom;
                    req_wdata  = $urandom;
                    req_funct3 = 3'($urandom_range(0, 7));
                    req_write  = 1'($urandom_range(0, 1));
                end
            end
        end
        chk("latency", n, exp_lat);
        chk("stall_resp", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ddt_i = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_funct3 = 3'b000;
        req_addr = '0;
        req_wdata = '0;
        ddt_i = '0;
        #1;
        chk("reset_bus", {DAD | ddt_o}, 32'd0);
        chk("reset_ctl", {26'd0, stall, rsp_valid, rsp_err, ddt_oe, MREQ, WRITE}, 32'd0);
        chk("reset_size_rdata", rsp_rdata | 32'(SIZE), 32'd0);
        req_valid = 1'b1;
        #1;
        chk("reset_stall", 32'(stall), 32'd0);
        req_valid = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(2);

        // Directed cases
        do_txn(1'b0, 3'b010, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 0);
        chk("lw_const", act_last_rdata, 32'hDEAD_BEEF);
        chk("lw_dad_const", bm_act_dad, 32'h0000_1004);
        do_txn(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_0000, 1);
        chk("lb_const", act_last_rdata, 32'hFFFF_FF80);
        do_txn(1'b0, 3'b100, 32'h0000_1003, 32'd0, 32'h80FF_0000, 0);
        chk("lbu_const", act_last_rdata, 32'h0000_0080);
        do_txn(1'b0, 3'b101, 32'h0000_1002, 32'd0, 32'h80FF_0000, 2);
        chk("lhu_const", act_last_rdata, 32'h0000_80FF);
        do_txn(1'b1, 3'b000, 32'h0000_2001, 32'h1234_56AB, 32'hFFFF_FFFF, 4);
        chk("sb_dad_const", bm_act_dad, 32'h0000_2000);
        chk("sb_ddt_const", bm_act_ddt, 32'h0000_AB00);
        chk("sb_rdata_const", act_last_rdata, 32'd0);
        do_txn(1'b0, 3'b001, 32'h0000_3001, 32'd0, 32'h1234_5678, 0);
        chk("lh_mis_err_const", 32'(act_last_err), 32'd1);
        do_txn(1'b1, 3'b011, 32'h0000_3000, 32'h5555_5555, 32'd0, 0);
        chk("sd_bad_err_const", 32'(act_last_err), 32'd1);
        idle(1);

        // Reset in the middle of a bus cycle: abandoned with no response
        begin
            bus_t b;
            b.dad = 32'h0000_4000; b.ddt = 32'd0; b.size = 2'b00; b.wr = 1'b1; b.wt = 6;
            bus_q.push_back(b);
            wait_cur = 6;
            req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_4000; req_wdata = 32'd0;
            req_valid = 1'b1;
            idle(1);
            req_valid = 1'b0;
            repeat (2) @(negedge clk);
            #2;
            abort = 1'b1;
            req_valid = 1'b1;
            rst = 1'b1;
            #1;
            chk("rst_mid_ctl", {28'd0, MREQ, ddt_oe, stall, rsp_valid}, 32'd0);
            chk("rst_mid_dad", DAD, 32'd0);
            idle(2);
            req_valid = 1'b0;
            rst = 1'b0;
            idle(2);
            abort = 1'b0;
        end
        do_txn(1'b0, 3'b010, 32'h0000_5008, 32'd0, 32'hCAFE_F00D, 1);
        chk("post_rst_const", act_last_rdata, 32'hCAFE_F00D);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, int'($urandom_range(0, 4)));
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
        end

        idle(4);
        chk("bus_q_drained", bus_q.size(), 32'd0);
        chk("rsp_q_drained", rsp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
